// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the ram_arbiter slice.
package ram_arbiter_pkg;

  // Index width sized for the largest supported requester count ($clog2(N) for N = 8).
  localparam int unsigned MAX_N = 8;
  localparam int unsigned IDX_W = $clog2(MAX_N);

  // Lock ownership state.
  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Index of the set bit in a one-hot (or zero) vector.
  function automatic logic [IDX_W-1:0] onehot_to_index(input logic [MAX_N-1:0] onehot);
    logic [IDX_W-1:0] index;
    index = '0;
    for (int i = 0; i < int'(MAX_N); i++) begin
      if (onehot[i]) index = index | IDX_W'(i);
    end
    return index;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first request after `last`, wrapping modulo N.
module rr_pick
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     pick_c,
  output logic [IDX_W-1:0] index_c
);

  logic [N-1:0] upper;
  logic [N-1:0] upper_req;
  logic [N-1:0] lowest_upper;
  logic [N-1:0] lowest_all;

  // Requesters strictly above the last winner get first chance.
  always_comb begin
    upper = '0;
    for (int i = 0; i < int'(N); i++) begin
      upper[i] = (IDX_W'(i) > last);
    end
  end

  assign upper_req = req & upper;

  // Lowest set bit of the upper slice and of the full request vector.
  always_comb begin
    lowest_upper = '0;
    lowest_all   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (upper_req[i]) begin
        lowest_upper    = '0;
        lowest_upper[i] = 1'b1;
      end
      if (req[i]) begin
        lowest_all    = '0;
        lowest_all[i] = 1'b1;
      end
    end
  end

  // Wrap to the bottom only when nothing above `last` is requesting.
  always_comb begin
    pick_c  = (|upper_req) ? lowest_upper : lowest_all;
    index_c = onehot_to_index(MAX_N'(pick_c));
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between N requesters.
// Optional grant locking is compiled in with RAM_ARBITER_LOCK_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_LOCK   = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N-1:0]            req,
  input  logic [N-1:0]            req_write,
  input  logic [N-1:0]            req_lock,
  input  logic [N*ADDR_WIDTH-1:0] req_address,
  input  logic [N*DATA_WIDTH-1:0] req_write_data,
  output logic [N-1:0]            grant,
  output logic [N-1:0]            read_valid,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    ram_write_enable,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic [DATA_WIDTH-1:0]   ram_write_data,
  input  logic [DATA_WIDTH-1:0]   ram_read_data
);

  logic [IDX_W-1:0] last;
  logic [N-1:0]     pick_c;
  logic [IDX_W-1:0] pick_index_c;
  logic             locked;
  logic             lock_hit;
  logic [N-1:0]     lock_grant;
  logic [IDX_W-1:0] lock_index;
  logic [N-1:0]     grant_raw;
  logic [IDX_W-1:0] grant_index;

  rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req     (req),
    .last    (last),
    .pick_c  (pick_c),
    .index_c (pick_index_c)
  );

`ifdef RAM_ARBITER_LOCK_EN
  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  lock_state_e      state;
  lock_state_e      state_next;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] owner_next;
  logic [CNT_W-1:0] lock_count;
  logic [CNT_W-1:0] lock_count_next;
  logic [N-1:0]     owner_onehot;
  logic             owner_req;
  logic             owner_lock;
  logic             pick_lock;

  // Decode the owner index so its request and lock bits can be selected.
  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < int'(N); i++) begin
      owner_onehot[i] = (IDX_W'(i) == owner);
    end
  end

  assign owner_req  = |(req & owner_onehot);
  assign owner_lock = |(req_lock & owner_onehot);
  assign pick_lock  = |(req_lock & pick_c);
  assign locked     = (state == LOCK_HELD);
  assign lock_hit   = locked & owner_req;
  assign lock_grant = owner_onehot;
  assign lock_index = owner;

  // Lock next-state: count owner grants, release on drop, unlock or budget exhaustion.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    lock_count_next = lock_count;
    if (lock_hit) begin
      if (!owner_lock || (lock_count == CNT_W'(MAX_LOCK - 1))) begin
        state_next      = LOCK_IDLE;
        lock_count_next = '0;
      end else begin
        lock_count_next = lock_count + CNT_W'(1);
      end
    end else begin
      state_next      = LOCK_IDLE;
      lock_count_next = '0;
      if ((|pick_c) && pick_lock && (MAX_LOCK > 1)) begin
        state_next      = LOCK_HELD;
        owner_next      = pick_index_c;
        lock_count_next = CNT_W'(1);
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LOCK_IDLE;
      owner      <= '0;
      lock_count <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      lock_count <= lock_count_next;
    end
  end
`else
  logic unused_lock;

  assign locked      = 1'b0;
  assign lock_hit    = locked;
  assign lock_grant  = '0;
  assign lock_index  = '0;
  assign unused_lock = ^{req_lock, 32'(MAX_LOCK)};
`endif

  // Lock override on top of the round-robin pick; reset forces no grant.
  always_comb begin
    grant_raw   = lock_hit ? lock_grant : pick_c;
    grant_index = lock_hit ? lock_index : pick_index_c;
    grant       = reset_n ? grant_raw : '0;
  end

  // RAM port mux; requester 0 fields are a don't-care default when idle.
  always_comb begin
    ram_address    = req_address[ADDR_WIDTH-1:0];
    ram_write_data = req_write_data[DATA_WIDTH-1:0];
    for (int i = 0; i < int'(N); i++) begin
      if (grant[i]) begin
        ram_address    = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_write_data = req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ram_write_enable = |(grant & req_write);
  assign read_data        = ram_read_data;

  // Round-robin pointer and one-cycle read return tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last       <= IDX_W'(N - 1);
      read_valid <= '0;
    end else begin
      read_valid <= grant & ~req_write;
      if (|grant) last <= grant_index;
    end
  end

endmodule
